hazard_ctrl: RTL

- Central pipeline-control block for the dual-issue MIPS core.
- Consumes the load-use stall requests from both lanes' forwarding units, the EX-stage taken-branch indication and the data-memory busy flag.
- Drives PC hold, IF/ID hold and flush, ID/EX bubble and flush, and same-pair lane-1 kill, keeping both lanes in lockstep.
- Maintains saturating stall, freeze and flush performance counters.

---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the dual-issue core: freeze, redirect/flush and
// load-use stall arbitration, plus saturating stall/freeze/flush event counters.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CWIDTH       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hz_i_stall_lane0,
    input  logic              hz_i_stall_lane1,
    input  logic              hz_i_branch_taken,
    input  logic              hz_i_branch_lane,
    input  logic              hz_i_mem_busy,
    output logic              hz_o_pc_hold,
    output logic              hz_o_ifid_hold,
    output logic              hz_o_idex_bubble,
    output logic              hz_o_ifid_flush,
    output logic              hz_o_idex_flush,
    output logic              hz_o_ex_kill_lane1,
    output logic              hz_o_pc_redirect,
    output logic              hz_o_freeze,
    output logic [1:0]        hz_o_state,
    output logic [CWIDTH-1:0] hz_o_stall_cnt,
    output logic [CWIDTH-1:0] hz_o_freeze_cnt,
    output logic [CWIDTH-1:0] hz_o_flush_cnt
);
    localparam int LW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, FREEZE = 2'd2} state_t;

    state_t        state_reg, state_next, saved_state_reg, cur_state;
    logic [LW-1:0] left_reg, left_next, saved_left_reg, cur_left;
    logic          pend_reg, pend_lane_reg;
    logic          do_freeze, do_redirect, do_flush, do_stall, redirect_lane;
    logic [2:0]    cnt_inc;

    // While frozen, the state that governs the exit cycle is the one saved on entry.
    always_comb begin
        cur_state     = (state_reg == FREEZE) ? saved_state_reg : state_reg;
        cur_left      = (state_reg == FREEZE) ? saved_left_reg  : left_reg;
        redirect_lane = (state_reg == FREEZE && pend_reg) ? pend_lane_reg : hz_i_branch_lane;
        do_freeze     = rst_n && hz_i_mem_busy;
        do_redirect   = rst_n && !hz_i_mem_busy &&
                        (hz_i_branch_taken || (state_reg == FREEZE && pend_reg));
        do_flush      = rst_n && !hz_i_mem_busy && !do_redirect && (cur_state == FLUSH);
        do_stall      = rst_n && !hz_i_mem_busy && !do_redirect && (cur_state == RUN) &&
                        (hz_i_stall_lane0 || hz_i_stall_lane1);
    end

    always_comb begin
        state_next = state_reg;
        left_next  = left_reg;
        if (hz_i_mem_busy) begin
            state_next = FREEZE;
        end else if (do_redirect) begin
            state_next = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            left_next  = LW'(FLUSH_CYCLES - 1);
        end else if (cur_state == FLUSH) begin
            if (cur_left <= LW'(1)) begin
                state_next = RUN;
                left_next  = '0;
            end else begin
                state_next = FLUSH;
                left_next  = cur_left - 1'b1;
            end
        end else begin
            state_next = RUN;
            left_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            left_reg        <= '0;
            saved_state_reg <= RUN;
            saved_left_reg  <= '0;
            pend_reg        <= 1'b0;
            pend_lane_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            left_reg  <= left_next;
            if (hz_i_mem_busy) begin
                if (state_reg != FREEZE) begin
                    saved_state_reg <= state_reg;
                    saved_left_reg  <= left_reg;
                end
                if (hz_i_branch_taken) begin
                    pend_reg      <= 1'b1;
                    pend_lane_reg <= hz_i_branch_lane;
                end
            end else begin
                pend_reg <= 1'b0;
            end
        end
    end

    assign hz_o_pc_hold       = do_freeze || do_stall;
    assign hz_o_ifid_hold     = do_freeze || do_stall;
    assign hz_o_idex_bubble   = do_stall;
    assign hz_o_ifid_flush    = do_redirect || do_flush;
    assign hz_o_idex_flush    = do_redirect || do_flush;
    assign hz_o_ex_kill_lane1 = do_redirect && !redirect_lane;
    assign hz_o_pc_redirect   = do_redirect;
    assign hz_o_freeze        = do_freeze;
    assign hz_o_state         = state_reg;

    assign cnt_inc = {do_redirect, do_freeze, do_stall};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CWIDTH-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_reg <= '0;
                else if (cnt_inc[gi] && (cnt_reg != {CWIDTH{1'b1}}))
                    cnt_reg <= cnt_reg + 1'b1;
            end
        end
    endgenerate

    assign hz_o_stall_cnt  = g_cnt[0].cnt_reg;
    assign hz_o_freeze_cnt = g_cnt[1].cnt_reg;
    assign hz_o_flush_cnt  = g_cnt[2].cnt_reg;
endmodule
